conv_window_ctrl: RTL and testbench



---
 rtl/npu_conv_pkg.sv | 25 ++
 rtl/conv_addr_gen.sv | 76 +++++++
 rtl/conv_window_ctrl.sv | 141 ++++++++++++++
 tb/tb_conv_window_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_conv_pkg.sv
// ============================================================================
// Module   : npu_conv_pkg
// Brief    : Shared types and constants for the 3x3 convolution sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package npu_conv_pkg;

  localparam int KERNEL = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_addr_gen.sv
// ============================================================================
// Module   : conv_addr_gen
// Brief    : Raster (row, col) walker with three incremental row-base
//            accumulators producing the window's three read addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_addr_gen
  import npu_conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       step,
  output logic [cnt_w(IMG_H)-1:0]    row,
  output logic [cnt_w(IMG_W)-1:0]    col,
  output logic [ADDR_W-1:0]          addr_r1,
  output logic [ADDR_W-1:0]          addr_r2,
  output logic [ADDR_W-1:0]          addr_r3,
  output logic                       last
);

  localparam int c_col_w = cnt_w(IMG_W);
  localparam int c_row_w = cnt_w(IMG_H);
  localparam logic [ADDR_W-1:0]  c_stride   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]  c_stride2  = ADDR_W'(2 * IMG_W);
  localparam logic [c_col_w-1:0] c_last_col = c_col_w'(IMG_W - 1);
  localparam logic [c_row_w-1:0] c_last_row = c_row_w'(IMG_H - KERNEL);

  logic [c_row_w-1:0] r_row;
  logic [c_col_w-1:0] r_col;
  logic [ADDR_W-1:0]  r_base1, r_base2, r_base3;

  // Row bases advance by one stride per row; the additions wrap modulo 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_base1 <= '0;
      r_base2 <= '0;
      r_base3 <= '0;
    end else if (load) begin
      r_row   <= '0;
      r_col   <= '0;
      r_base1 <= base_addr;
      r_base2 <= base_addr + c_stride;
      r_base3 <= base_addr + c_stride2;
    end else if (step) begin
      if (r_col == c_last_col) begin
        r_col   <= '0;
        r_row   <= r_row + 1'b1;
        r_base1 <= r_base1 + c_stride;
        r_base2 <= r_base2 + c_stride;
        r_base3 <= r_base3 + c_stride;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign row     = r_row;
  assign col     = r_col;
  assign addr_r1 = r_base1 + ADDR_W'(r_col);
  assign addr_r2 = r_base2 + ADDR_W'(r_col);
  assign addr_r3 = r_base3 + ADDR_W'(r_col);
  assign last    = (r_row == c_last_row) && (r_col == c_last_col);

endmodule

`default_nettype wire

// File: rtl/conv_window_ctrl.sv
// ============================================================================
// Module   : conv_window_ctrl
// Brief    : Frame sequencer for the 3x3 convolution line buffer: issues
//            pixel reads, drives line-buffer strobes, reports windows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_ctrl
  import npu_conv_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic                       stall,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr_r1,
  output logic [ADDR_W-1:0]          mem_addr_r2,
  output logic [ADDR_W-1:0]          mem_addr_r3,
  output logic                       lb_wr_en,
  output logic                       lb_shift,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col
);

  localparam int c_col_w = cnt_w(IMG_W);
  localparam int c_row_w = cnt_w(IMG_H);
  localparam logic [c_col_w-1:0] c_first_win_col = c_col_w'(KERNEL - 1);

  if (IMG_W < KERNEL) begin : g_chk_img_w
    $error("conv_window_ctrl: IMG_W must be at least 3");
  end
  if (IMG_H < KERNEL) begin : g_chk_img_h
    $error("conv_window_ctrl: IMG_H must be at least 3");
  end

  state_t             r_state, w_state_nxt;
  logic               w_rd, w_load, w_last;
  logic [c_row_w-1:0] w_row;
  logic [c_col_w-1:0] w_col;

  logic               r_lb_wr, r_s1_last;
  logic [c_row_w-1:0] r_s1_row;
  logic [c_col_w-1:0] r_s1_col;
  logic               r_win_valid, r_done;
  logic [c_row_w-1:0] r_win_row;
  logic [c_col_w-1:0] r_win_col;

  conv_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .base_addr (base_addr),
    .step      (w_rd),
    .row       (w_row),
    .col       (w_col),
    .addr_r1   (mem_addr_r1),
    .addr_r2   (mem_addr_r2),
    .addr_r3   (mem_addr_r3),
    .last      (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (!stall) begin
          w_rd = 1'b1;
          if (w_last) w_state_nxt = DRAIN;
        end
      end
      // Reads are finished; wait for the final window to leave the pipeline.
      DRAIN: begin
        if (r_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lb_wr     <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_row    <= '0;
      r_s1_col    <= '0;
      r_win_valid <= 1'b0;
      r_done      <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_lb_wr     <= w_rd;
      r_s1_last   <= w_rd && w_last;
      r_s1_row    <= w_row;
      r_s1_col    <= w_col;
      // Columns 0 and 1 only prime the line buffer and never form a window.
      r_win_valid <= r_lb_wr && (r_s1_col >= c_first_win_col);
      r_done      <= r_lb_wr && r_s1_last;
      if (r_lb_wr && (r_s1_col >= c_first_win_col)) begin
        r_win_row <= r_s1_row;
        r_win_col <= r_s1_col - c_first_win_col;
      end
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign mem_rd_en = w_rd;
  assign lb_wr_en  = r_lb_wr;
  assign lb_shift  = r_lb_wr;
  assign win_valid = r_win_valid;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
// ============================================================================
// Module   : tb_conv_window_ctrl
// Brief    : Self-checking bench for conv_window_ctrl on a 4x4 frame, a 4x4
//            frame with 8-bit wrapping addresses and an 8x8 frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic [15:0] base_a = 16'h0100;
  logic [7:0]  base_b = 8'hFC;
  logic [15:0] base_c = 16'h2000;

  logic [2:0]  busy, done, rd, lbw, lbs, wv;
  logic [15:0] a1 [3];
  logic [15:0] a2 [3];
  logic [15:0] a3 [3];
  logic [2:0]  row [3];
  logic [2:0]  col [3];
  logic [1:0]  row_a, col_a, row_b, col_b;
  logic [7:0]  b_a1, b_a2, b_a3;

  always #5 clk = ~clk;

  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_a), .stall(stall),
    .busy(busy[0]), .done(done[0]), .mem_rd_en(rd[0]),
    .mem_addr_r1(a1[0]), .mem_addr_r2(a2[0]), .mem_addr_r3(a3[0]),
    .lb_wr_en(lbw[0]), .lb_shift(lbs[0]), .win_valid(wv[0]),
    .win_row(row_a), .win_col(col_a)
  );

  conv_window_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_b), .stall(stall),
    .busy(busy[1]), .done(done[1]), .mem_rd_en(rd[1]),
    .mem_addr_r1(b_a1), .mem_addr_r2(b_a2), .mem_addr_r3(b_a3),
    .lb_wr_en(lbw[1]), .lb_shift(lbs[1]), .win_valid(wv[1]),
    .win_row(row_b), .win_col(col_b)
  );

  conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .ADDR_W(16)) u_c (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_c), .stall(stall),
    .busy(busy[2]), .done(done[2]), .mem_rd_en(rd[2]),
    .mem_addr_r1(a1[2]), .mem_addr_r2(a2[2]), .mem_addr_r3(a3[2]),
    .lb_wr_en(lbw[2]), .lb_shift(lbs[2]), .win_valid(wv[2]),
    .win_row(row[2]), .win_col(col[2])
  );

  assign row[0] = {1'b0, row_a};
  assign col[0] = {1'b0, col_a};
  assign row[1] = {1'b0, row_b};
  assign col[1] = {1'b0, col_b};
  assign a1[1]  = {8'h00, b_a1};
  assign a2[1]  = {8'h00, b_a2};
  assign a3[1]  = {8'h00, b_a3};

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a frame is the list of reads 0..N-1 in raster order; read k addresses
  // base+k (+W, +2W), is written one cycle later and reported one cycle after that.
  int m_w [3] = '{4, 4, 8};
  int m_h [3] = '{4, 4, 8};
  int m_aw[3] = '{16, 8, 16};
  bit     m_busy[3];
  int     m_k [3];
  int     m_p1[3];
  int     m_p2[3];
  longint m_base[3];

  // Event logs for the hand-computed checks.
  int cur_rel;
  int a_wv[$];
  int a_wr[$];
  int a_wc[$];
  int a_rd[$];
  int a_done_rel, a_busy_fall;
  bit a_prev_busy;
  bit first_seen[3];
  longint first_a[3][3];
  int c_wins;

  function automatic longint base_of(input int i);
    if (i == 0) return longint'(base_a);
    if (i == 1) return longint'(base_b);
    return longint'(base_c);
  endfunction

  task automatic model_step(input int i);
    int n;
    longint mask, ea;
    bit erd, elb, ewv, edn;
    string p;
    p    = $sformatf("u%0d", i);
    n    = (m_h[i] - 2) * m_w[i];
    mask = (longint'(1) << m_aw[i]) - 1;
    if (rst) begin
      m_busy[i] = 1'b0; m_k[i] = 0; m_p1[i] = -1; m_p2[i] = -1;
    end
    erd = m_busy[i] && (m_k[i] < n) && !stall;
    elb = (m_p1[i] >= 0);
    ewv = (m_p2[i] >= 0) && ((m_p2[i] % m_w[i]) >= 2);
    edn = ewv && (m_p2[i] == n - 1);
    chk({p, " busy"},      busy[i], m_busy[i]);
    chk({p, " mem_rd_en"}, rd[i],   erd);
    chk({p, " lb_wr_en"},  lbw[i],  elb);
    chk({p, " lb_shift"},  lbs[i],  elb);
    chk({p, " win_valid"}, wv[i],   ewv);
    chk({p, " done"},      done[i], edn);
    if (erd) begin
      ea = m_base[i] + m_k[i];
      chk({p, " addr_r1"}, a1[i], ea & mask);
      chk({p, " addr_r2"}, a2[i], (ea + m_w[i]) & mask);
      chk({p, " addr_r3"}, a3[i], (ea + 2 * m_w[i]) & mask);
    end
    if (ewv) begin
      chk({p, " win_row"}, row[i], m_p2[i] / m_w[i]);
      chk({p, " win_col"}, col[i], (m_p2[i] % m_w[i]) - 2);
    end
    if (rst) begin
      chk({p, " rst addr_r1"}, a1[i], 0);
      chk({p, " rst win_row"}, row[i], 0);
    end
    // logging
    if (rd[i] && !first_seen[i]) begin
      first_seen[i] = 1'b1;
      first_a[i][0] = a1[i]; first_a[i][1] = a2[i]; first_a[i][2] = a3[i];
    end
    if (i == 0) begin
      if (rd[0]) a_rd.push_back(cur_rel);
      if (wv[0]) begin
        a_wv.push_back(cur_rel); a_wr.push_back(row[0]); a_wc.push_back(col[0]);
      end
      if (done[0] && a_done_rel < 0) a_done_rel = cur_rel;
      if (a_prev_busy && !busy[0] && a_busy_fall < 0) a_busy_fall = cur_rel;
      a_prev_busy = busy[0];
    end
    if (i == 2 && wv[2]) begin
      chk("u2 raster row", row[2], c_wins / 6);
      chk("u2 raster col", col[2], c_wins % 6);
      c_wins++;
    end
    if (!rst) begin
      m_p2[i] = m_p1[i];
      m_p1[i] = erd ? m_k[i] : -1;
      if (erd) m_k[i]++;
      if (edn) m_busy[i] = 1'b0;
      else if (!m_busy[i] && start) begin
        m_busy[i] = 1'b1; m_k[i] = 0; m_base[i] = base_of(i);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic clear_logs();
    a_wv.delete(); a_wr.delete(); a_wc.delete(); a_rd.delete();
    a_done_rel = -1; a_busy_fall = -1; c_wins = 0;
    for (int i = 0; i < 3; i++) first_seen[i] = 1'b0;
  endtask

  task automatic run(input int len, input int st2, input int st3, input int s_lo,
                     input int s_hi, input int rst_at, input bit rnd);
    clear_logs();
    for (int rel = 0; rel < len; rel++) begin
      cur_rel = rel;
      start = (rel == 0) || (rel == st2) || (rel == st3);
      stall = (rel >= s_lo && rel <= s_hi) || (rnd && ($urandom_range(0, 3) == 0));
      rst   = (rel == rst_at);
      @(posedge clk); #1;
    end
    start = 1'b0; stall = 1'b0; rst = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy != 3'b000 && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk("idle within bound", busy, 0);
  endtask

  task automatic check_basic(input int sh);
    int exp_w[4] = '{5, 6, 9, 10};
    chk("A first read cycle", (a_rd.size() > 0) ? a_rd[0] : -1, 1);
    chk("A first addr_r1", first_a[0][0], 16'h100);
    chk("A first addr_r2", first_a[0][1], 16'h104);
    chk("A first addr_r3", first_a[0][2], 16'h108);
    chk("A window count", a_wv.size(), 4);
    for (int j = 0; j < 4 && j < a_wv.size(); j++) begin
      chk($sformatf("A win%0d cycle", j), a_wv[j], exp_w[j] + sh);
      chk($sformatf("A win%0d row", j), a_wr[j], j / 2);
      chk($sformatf("A win%0d col", j), a_wc[j], j % 2);
    end
    chk("A done cycle", a_done_rel, 10 + sh);
    chk("A busy fall cycle", a_busy_fall, 11 + sh);
    chk("C window count", c_wins, 36);
  endtask

  initial begin
    int n_stall_rd, first_late;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset mem_rd_en", rd, 0);
    chk("reset lb_wr_en", lbw, 0);
    chk("reset lb_shift", lbs, 0);
    chk("reset win_valid", wv, 0);
    chk("reset A addr_r1", a1[0], 0);
    chk("reset A addr_r2", a2[0], 0);
    chk("reset A addr_r3", a3[0], 0);
    chk("reset A win_row", row[0], 0);
    chk("reset A win_col", col[0], 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame.
    run(55, -1, -1, -1, -1, -1, 1'b0);
    check_basic(0);
    chk("B first addr_r1", first_a[1][0], 8'hFC);
    chk("B first addr_r2", first_a[1][1], 8'h00);
    chk("B first addr_r3", first_a[1][2], 8'h04);
    wait_idle();

    // Stall in cycles 3..5.
    run(58, -1, -1, 3, 5, -1, 1'b0);
    check_basic(3);
    n_stall_rd = 0;
    foreach (a_rd[j]) if (a_rd[j] >= 3 && a_rd[j] <= 5) n_stall_rd++;
    chk("A reads during stall", n_stall_rd, 0);
    wait_idle();

    // Start while busy, then back-to-back start.
    run(60, 4, 11, -1, -1, -1, 1'b0);
    chk("A reads two frames", a_rd.size(), 16);
    chk("A windows two frames", a_wv.size(), 8);
    chk("A first frame done", a_done_rel, 10);
    first_late = -1;
    foreach (a_rd[j]) if (a_rd[j] > 10 && first_late < 0) first_late = a_rd[j];
    chk("A second frame first read", first_late, 12);
    chk("C windows with extra starts", c_wins, 36);
    wait_idle();

    // Reset mid-frame, then a clean frame.
    run(20, -1, -1, -1, -1, 6, 1'b0);
    chk("A windows before reset", a_wv.size(), 1);
    chk("A idle after reset", busy, 0);
    run(55, -1, -1, -1, -1, -1, 1'b0);
    check_basic(0);
    wait_idle();

    // Random stall.
    run(200, -1, -1, -1, -1, -1, 1'b1);
    chk("C windows random stall", c_wins, 36);
    chk("A windows random stall", a_wv.size(), 4);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
